spi_mem_arbiter: RTL and testbench

Two-port arbiter that shares one SPI SRAM master between two memory requesters, for example the 6502 core and a DMA/video fetch engine. It sits between the requesters and the SPI SRAM master's mem_* interface. Each access is granted atomically and completion is returned to the owning port. Arbitration is round-robin, and a per-port lock lets one port keep consecutive accesses for sequential bursts.

---
 rtl/spi_mem_arbiter_pkg.sv | 31 +++
 rtl/spi_mem_arbiter_if.sv | 25 ++
 rtl/spi_mem_arbiter_rr_pick.sv | 13 +
 rtl/spi_mem_arbiter.sv | 114 +++++++++++
 tb/tb_spi_mem_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_mem_arbiter_pkg.sv
// Shared types and the 2-way round-robin/lock pick function for the SPI SRAM arbiter.
package spi_arb_pkg;
  localparam int ADDR_W = 24;
  localparam int DATA_W = 8;

  typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              wr;
    logic [DATA_W-1:0] wdata;
  } mem_req_t;

  // Returns {grant_valid, grant_idx}. A held lock masks the port that does not own it.
  function automatic logic [1:0] arb_pick(input logic [1:0] valid, input logic last_owner,
                                          input logic lock_hold, input logic owner);
    logic [1:0] v;
    logic [1:0] res;
    v = valid;
    if (lock_hold) begin
      v = owner ? (valid & 2'b10) : (valid & 2'b01);
    end
    case (v)
      2'b01:   res = 2'b10;
      2'b10:   res = 2'b11;
      2'b11:   res = {1'b1, ~last_owner};
      default: res = 2'b00;
    endcase
    return res;
  endfunction
endpackage

// File: rtl/spi_mem_arbiter_if.sv
// Requester-side and SPI-master-side bus bundles for the SPI SRAM arbiter.
interface spi_arb_req_if;
  logic                           valid;
  logic [spi_arb_pkg::ADDR_W-1:0] addr;
  logic                           wr;
  logic [spi_arb_pkg::DATA_W-1:0] wdata;
  logic                           lock;
  logic                           ready;
  logic [spi_arb_pkg::DATA_W-1:0] rdata;

  modport master (output valid, addr, wr, wdata, lock, input ready, rdata);
  modport slave  (input valid, addr, wr, wdata, lock, output ready, rdata);
endinterface

interface spi_arb_mem_if;
  logic [spi_arb_pkg::ADDR_W-1:0] addr;
  logic                           en;
  logic                           wr;
  logic [spi_arb_pkg::DATA_W-1:0] wdata;
  logic                           rdy;
  logic [spi_arb_pkg::DATA_W-1:0] rdata;

  modport master (output addr, en, wr, wdata, input rdy, rdata);
  modport slave  (input addr, en, wr, wdata, output rdy, rdata);
endinterface

// File: rtl/spi_mem_arbiter_rr_pick.sv
// Combinational 2-way round-robin picker with per-port lock masking.
module spi_arb_rr_pick
  import spi_arb_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       last_owner,
  input  logic       lock_hold,
  input  logic       owner,
  output logic       grant_valid,
  output logic       grant_idx
);
  assign {grant_valid, grant_idx} = arb_pick(valid, last_owner, lock_hold, owner);
endmodule

// File: rtl/spi_mem_arbiter.sv
// Shares one SPI SRAM master between two requesters; one atomic access at a time,
// round-robin on ties, optional lock to keep consecutive accesses on one port.
module spi_mem_arbiter
  import spi_arb_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  spi_arb_req_if.slave  p0,
  spi_arb_req_if.slave  p1,
  spi_arb_mem_if.master mem,
  output logic          busy_owner
);
  arb_state_t state_q, state_d;
  mem_req_t   req_q, req_d;
  logic       owner_q, owner_d;
  logic       last_owner_q, last_owner_d;
  logic       lock_hold_q, lock_hold_d;

  logic [1:0] req_valid, req_lock, pick_valid;
  logic       pick_lock, grant_valid, grant_idx, done;
  mem_req_t   win_req;

  assign req_valid = {p1.valid, p0.valid};
  assign req_lock  = {p1.lock, p0.lock};
  assign done      = (state_q == ARB_BUSY) && mem.rdy;

  // On completion the finishing port is out of the race and its lock bit decides masking now.
  always_comb begin
    pick_valid = req_valid;
    pick_lock  = lock_hold_q;
    if (done) begin
      pick_valid[owner_q] = 1'b0;
      pick_lock           = req_lock[owner_q];
    end
  end

  spi_arb_rr_pick u_pick (
    .valid       (pick_valid),
    .last_owner  (last_owner_q),
    .lock_hold   (pick_lock),
    .owner       (owner_q),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  always_comb begin
    win_req = grant_idx ? '{addr: p1.addr, wr: p1.wr, wdata: p1.wdata}
                        : '{addr: p0.addr, wr: p0.wr, wdata: p0.wdata};
  end

  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    lock_hold_d  = lock_hold_q;
    case (state_q)
      ARB_IDLE: begin
        if (grant_valid) begin
          state_d      = ARB_BUSY;
          req_d        = win_req;
          owner_d      = grant_idx;
          last_owner_d = grant_idx;
          lock_hold_d  = 1'b0;
        end else if (lock_hold_q && !req_valid[owner_q]) begin
          // Locked port went quiet for a whole idle cycle: release so the other side cannot starve.
          lock_hold_d = 1'b0;
        end
      end
      ARB_BUSY: begin
        if (mem.rdy) begin
          lock_hold_d = req_lock[owner_q];
          if (grant_valid) begin
            req_d        = win_req;
            owner_d      = grant_idx;
            last_owner_d = grant_idx;
            lock_hold_d  = 1'b0;
          end else begin
            state_d = ARB_IDLE;
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ARB_IDLE;
      req_q        <= '0;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      lock_hold_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      lock_hold_q  <= lock_hold_d;
    end
  end

  assign mem.en    = (state_q == ARB_BUSY);
  assign mem.addr  = req_q.addr;
  assign mem.wr    = req_q.wr;
  assign mem.wdata = req_q.wdata;

  assign p0.ready  = done && !owner_q;
  assign p1.ready  = done && owner_q;
  assign p0.rdata  = mem.rdata;
  assign p1.rdata  = mem.rdata;

  assign busy_owner = owner_q;
endmodule

// File: tb/tb_spi_mem_arbiter.sv
// Scoreboard bench for spi_mem_arbiter: drivers push expected grants/responses,
// a negedge monitor pops and compares whenever the DUT starts an access or pulses ready.
module tb_spi_mem_arbiter;
  import spi_arb_pkg::*;

  typedef struct packed {
    logic        port;
    logic [23:0] addr;
    logic        wr;
    logic [7:0]  wdata;
  } grant_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_arb_req_if p0_if ();
  spi_arb_req_if p1_if ();
  spi_arb_mem_if mem_if ();
  logic busy_owner;

  logic        rq_valid [2];
  logic [23:0] rq_addr  [2];
  logic        rq_wr    [2];
  logic [7:0]  rq_wdata [2];
  logic        rq_lock  [2];
  logic        spi_rdy;
  logic [7:0]  spi_rdata;
  bit          inject_spur;
  int          spi_lat;

  assign p0_if.valid = rq_valid[0];
  assign p0_if.addr  = rq_addr[0];
  assign p0_if.wr    = rq_wr[0];
  assign p0_if.wdata = rq_wdata[0];
  assign p0_if.lock  = rq_lock[0];
  assign p1_if.valid = rq_valid[1];
  assign p1_if.addr  = rq_addr[1];
  assign p1_if.wr    = rq_wr[1];
  assign p1_if.wdata = rq_wdata[1];
  assign p1_if.lock  = rq_lock[1];
  assign mem_if.rdy   = spi_rdy;
  assign mem_if.rdata = spi_rdata;

  spi_mem_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .p0         (p0_if.slave),
    .p1         (p1_if.slave),
    .mem        (mem_if.master),
    .busy_owner (busy_owner)
  );

  grant_t     exp_grant_q [$];
  logic [8:0] exp_resp0_q [$];
  logic [8:0] exp_resp1_q [$];
  int n_cmp = 0;
  int n_fail = 0;
  int en_falls = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic port_ready(input int p);
    return (p == 0) ? p0_if.ready : p1_if.ready;
  endfunction

  function automatic logic [7:0] spi_rd(input logic [23:0] a);
    return a[7:0] ^ 8'h86;
  endfunction

  task automatic push_grant(input logic port, input logic [23:0] addr, input logic wr,
                            input logic [7:0] wdata);
    grant_t g;
    g = '{port: port, addr: addr, wr: wr, wdata: wdata};
    exp_grant_q.push_back(g);
  endtask

  // One request on one port, held until ready, then valid dropped just after the next edge.
  task automatic do_req(input int port, input logic [23:0] addr, input logic wr,
                        input logic [7:0] wdata, input logic lock, input logic [7:0] exp_rdata);
    bit got;
    got = 1'b0;
    if (port == 0) exp_resp0_q.push_back({wr, exp_rdata});
    else           exp_resp1_q.push_back({wr, exp_rdata});
    rq_addr[port]  = addr;
    rq_wr[port]    = wr;
    rq_wdata[port] = wdata;
    rq_lock[port]  = lock;
    rq_valid[port] = 1'b1;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (port_ready(port)) begin
        got = 1'b1;
        break;
      end
    end
    check($sformatf("p%0d_done_%06h", port, addr), 64'(got), 64'(1));
    @(posedge clk);
    #1;
    rq_valid[port] = 1'b0;
  endtask

  // SPI SRAM model: answers each access spi_lat cycles after mem_en, can inject a stray mem_rdy.
  task automatic spi_model();
    int cnt;
    cnt = 0;
    forever begin
      @(posedge clk);
      #2;
      if (rst) begin
        spi_rdy = 1'b0;
        cnt = 0;
      end else if (spi_rdy) begin
        spi_rdy = 1'b0;
        cnt = 0;
      end else if (inject_spur && !mem_if.en) begin
        spi_rdy = 1'b1;
        spi_rdata = 8'hEE;
        inject_spur = 1'b0;
      end else if (mem_if.en) begin
        cnt++;
        if (cnt >= spi_lat) begin
          spi_rdy = 1'b1;
          spi_rdata = mem_if.wr ? 8'h00 : spi_rd(mem_if.addr);
        end
      end else begin
        cnt = 0;
      end
    end
  endtask

  task automatic monitor();
    logic prev_en, prev_rdy, unstable;
    grant_t cur, act, g;
    logic [8:0] e;
    prev_en = 1'b0;
    prev_rdy = 1'b0;
    unstable = 1'b0;
    cur = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_en = 1'b0;
        prev_rdy = 1'b0;
      end else begin
        act = '{port: busy_owner, addr: mem_if.addr, wr: mem_if.wr, wdata: mem_if.wdata};
        if (mem_if.en && (!prev_en || prev_rdy)) begin
          if (exp_grant_q.size() == 0) begin
            check("unexpected_grant", 64'(act), 64'(0));
          end else begin
            g = exp_grant_q.pop_front();
            check("grant", 64'(act), 64'(g));
          end
          cur = act;
          unstable = 1'b0;
        end else if (mem_if.en && (act != cur)) begin
          unstable = 1'b1;
        end
        if (mem_if.en && mem_if.rdy) check("busy_fields_stable", 64'(unstable), 64'(0));
        if (p0_if.ready) begin
          if (exp_resp0_q.size() == 0) check("p0_unexpected_ready", 64'(1), 64'(0));
          else begin
            e = exp_resp0_q.pop_front();
            if (!e[8]) check("p0_rdata", 64'(p0_if.rdata), 64'(e[7:0]));
          end
        end
        if (p1_if.ready) begin
          if (exp_resp1_q.size() == 0) check("p1_unexpected_ready", 64'(1), 64'(0));
          else begin
            e = exp_resp1_q.pop_front();
            if (!e[8]) check("p1_rdata", 64'(p1_if.rdata), 64'(e[7:0]));
          end
        end
        if (prev_en && !mem_if.en) en_falls++;
        prev_en = mem_if.en;
        prev_rdy = mem_if.rdy;
      end
    end
  endtask

  initial begin
    int falls0;
    bit seen;
    logic [7:0] tie_rd0 [4];
    logic [7:0] tie_rd1 [4];
    tie_rd0 = '{8'h96, 8'h97, 8'h94, 8'h95};
    tie_rd1 = '{8'hA6, 8'hA7, 8'hA4, 8'hA5};
    for (int i = 0; i < 2; i++) begin
      rq_valid[i] = 1'b0; rq_addr[i] = '0; rq_wr[i] = 1'b0; rq_wdata[i] = '0; rq_lock[i] = 1'b0;
    end
    spi_rdy = 1'b0;
    spi_rdata = '0;
    inject_spur = 1'b0;
    spi_lat = 3;
    fork
      spi_model();
      monitor();
    join_none

    // reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_mem_en", 64'(mem_if.en), 64'(0));
    check("rst_mem_wr", 64'(mem_if.wr), 64'(0));
    check("rst_mem_addr", 64'(mem_if.addr), 64'(0));
    check("rst_mem_wdata", 64'(mem_if.wdata), 64'(0));
    check("rst_busy_owner", 64'(busy_owner), 64'(0));
    check("rst_ready", 64'({p1_if.ready, p0_if.ready}), 64'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;

    // tie from reset: strict alternation, mem_en never drops
    for (int i = 0; i < 4; i++) begin
      push_grant(1'b0, 24'h000010 + 24'(i), 1'b0, 8'h00);
      push_grant(1'b1, 24'h000020 + 24'(i), 1'b0, 8'h00);
    end
    falls0 = en_falls;
    fork
      for (int i = 0; i < 4; i++) do_req(0, 24'h000010 + 24'(i), 1'b0, 8'h00, 1'b0, tie_rd0[i]);
      for (int i = 0; i < 4; i++) do_req(1, 24'h000020 + 24'(i), 1'b0, 8'h00, 1'b0, tie_rd1[i]);
    join
    repeat (3) @(posedge clk);
    check("tie_en_falls", 64'(en_falls - falls0), 64'(1));

    // single read with a slow SPI response
    spi_lat = 20;
    @(posedge clk);
    #1;
    push_grant(1'b0, 24'h000123, 1'b0, 8'h00);
    fork
      do_req(0, 24'h000123, 1'b0, 8'h00, 1'b0, 8'hA5);
      begin
        @(negedge clk);
        check("single_en_before", 64'(mem_if.en), 64'(0));
        @(negedge clk);
        check("single_en_after1", 64'(mem_if.en), 64'(1));
      end
    join
    check("single_en_drop", 64'(mem_if.en), 64'(0));

    // lock burst on p1 while p0 waits
    spi_lat = 3;
    repeat (2) @(posedge clk);
    #1;
    push_grant(1'b1, 24'h000030, 1'b0, 8'h00);
    push_grant(1'b1, 24'h000031, 1'b0, 8'h00);
    push_grant(1'b1, 24'h000032, 1'b0, 8'h00);
    push_grant(1'b0, 24'h000040, 1'b0, 8'h00);
    push_grant(1'b0, 24'h000041, 1'b0, 8'h00);
    fork
      begin
        do_req(1, 24'h000030, 1'b0, 8'h00, 1'b1, 8'hB6);
        do_req(1, 24'h000031, 1'b0, 8'h00, 1'b1, 8'hB7);
        do_req(1, 24'h000032, 1'b0, 8'h00, 1'b0, 8'hB4);
      end
      begin
        @(posedge clk);
        #1;
        do_req(0, 24'h000040, 1'b0, 8'h00, 1'b0, 8'hC6);
        do_req(0, 24'h000041, 1'b0, 8'h00, 1'b0, 8'hC7);
      end
    join

    // lock release: p1 completes locked then goes quiet, p0 must still get through
    repeat (2) @(posedge clk);
    #1;
    push_grant(1'b1, 24'h000050, 1'b0, 8'h00);
    push_grant(1'b0, 24'h000060, 1'b0, 8'h00);
    fork
      do_req(1, 24'h000050, 1'b0, 8'h00, 1'b1, 8'hD6);
      begin
        @(posedge clk);
        #1;
        do_req(0, 24'h000060, 1'b0, 8'h00, 1'b0, 8'hE6);
      end
    join

    // write passthrough
    repeat (2) @(posedge clk);
    #1;
    push_grant(1'b1, 24'h00FFFE, 1'b1, 8'h5A);
    do_req(1, 24'h00FFFE, 1'b1, 8'h5A, 1'b0, 8'h00);

    // stray mem_rdy while idle
    repeat (2) @(posedge clk);
    inject_spur = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("spur_en", 64'(mem_if.en), 64'(0));
    check("spur_owner", 64'(busy_owner), 64'(1));

    // reset in the middle of a p0 read
    spi_lat = 20;
    @(posedge clk);
    #1;
    push_grant(1'b0, 24'h0000AA, 1'b0, 8'h00);
    rq_addr[0] = 24'h0000AA; rq_wr[0] = 1'b0; rq_wdata[0] = 8'h00; rq_lock[0] = 1'b0;
    rq_valid[0] = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (mem_if.en) begin
        seen = 1'b1;
        break;
      end
    end
    check("rst_abort_granted", 64'(seen), 64'(1));
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    rq_valid[0] = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_abort_en", 64'(mem_if.en), 64'(0));
    check("rst_abort_state", 64'(dut.state_q), 64'(ARB_IDLE));
    spi_lat = 3;
    push_grant(1'b1, 24'h000070, 1'b0, 8'h00);
    do_req(1, 24'h000070, 1'b0, 8'h00, 1'b0, 8'hF6);

    repeat (4) @(posedge clk);
    check("left_grants", 64'(exp_grant_q.size()), 64'(0));
    check("left_p0_resp", 64'(exp_resp0_q.size()), 64'(0));
    check("left_p1_resp", 64'(exp_resp1_q.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
